// File: rtl/car_motion_ctrl.sv
// car_motion_ctrl: player-car horizontal motion for the racing game.
// Continuous steering with hold-to-accelerate, or lane-snap mode with a
// fixed-speed glide toward the selected lane centre.
// Ports:
//   iVGA_CLK, iRST_n         clock, async active-low reset
//   reset_game               sync restart (active-high)
//   key_left, key_right      async steering keys (active-high)
//   lane_mode                0 = continuous, 1 = lane snap (async)
//   car_h_pos, car_v_pos     car top-left pixel position (registered)
//   lane_idx                 current target lane (registered)
//   moving                   position changed on the last tick (registered)
//   at_left, at_right        combinational bound flags
module car_motion_ctrl #(
   parameter int unsigned H_W        = 10,
   parameter int unsigned V_W        = 9,
   parameter int unsigned CAR_W      = 50,
   parameter int unsigned TRACK_L    = 120,
   parameter int unsigned TRACK_R    = 520,
   parameter int unsigned START_H    = 295,
   parameter int unsigned START_V    = 400,
   parameter int unsigned TICK_DIV   = 50000,
   parameter int unsigned STEP_MIN   = 2,
   parameter int unsigned STEP_MAX   = 8,
   parameter int unsigned RAMP_TICKS = 4,
   parameter int unsigned NUM_LANES  = 4,
   parameter int unsigned START_LANE = 1
) (
   input  logic                         iVGA_CLK,
   input  logic                         iRST_n,
   input  logic                         reset_game,
   input  logic                         key_left,
   input  logic                         key_right,
   input  logic                         lane_mode,
   output logic [H_W-1:0]               car_h_pos,
   output logic [V_W-1:0]               car_v_pos,
   output logic [$clog2(NUM_LANES)-1:0] lane_idx,
   output logic                         moving,
   output logic                         at_left,
   output logic                         at_right
);

   localparam int unsigned HX       = H_W + 1;
   localparam int unsigned MAX_H    = TRACK_R - CAR_W;
   localparam int unsigned LANE_W   = $clog2(NUM_LANES);
   localparam int unsigned LANE_PIX = (TRACK_R - TRACK_L) / NUM_LANES;
   localparam int unsigned LANE_OFF = (LANE_PIX - CAR_W) / 2;
   localparam int unsigned TICK_W   = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
   localparam int unsigned SPD_W    = $clog2(STEP_MAX + 1);
   localparam int unsigned HOLD_W   = $clog2(RAMP_TICKS + 1);

   typedef enum logic [1:0] {
      DIR_NONE  = 2'd0,
      DIR_LEFT  = 2'd1,
      DIR_RIGHT = 2'd2
   } dir_t;

   // Synchronisers plus one history stage each for edge detection
   logic r_kl_s1, r_kl_s2, r_kl_d;
   logic r_kr_s1, r_kr_s2, r_kr_d;
   logic r_lm_s1, r_lm_s2, r_lm_d;

   logic [TICK_W-1:0] r_tick_cnt, n_tick;
   logic [H_W-1:0]    r_h_pos, n_pos;
   logic [LANE_W-1:0] r_lane, n_lane;
   logic [SPD_W-1:0]  r_speed, n_speed;
   logic [HOLD_W-1:0] r_hold, n_hold;
   dir_t              r_dir, n_dir;
   logic              r_moving, n_moving;

   logic              w_tick;
   logic              w_kl_rise, w_kr_rise, w_lm_rise;
   logic [HX-1:0]     w_pos_x, w_tgt, w_new_x;
   logic [SPD_W-1:0]  w_spd_eff;
   logic [HOLD_W-1:0] w_hold_eff, w_hold_inc;
   dir_t              w_dir_eff, w_cur_dir;

   // Lane centre position for a given lane index
   function automatic logic [HX-1:0] f_target(input logic [LANE_W-1:0] idx);
      return HX'(TRACK_L + LANE_OFF) + HX'(idx) * HX'(LANE_PIX);
   endfunction

   // Input synchronisers; only the hard reset clears them
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_kl_s1 <= 1'b0; r_kl_s2 <= 1'b0; r_kl_d <= 1'b0;
         r_kr_s1 <= 1'b0; r_kr_s2 <= 1'b0; r_kr_d <= 1'b0;
         r_lm_s1 <= 1'b0; r_lm_s2 <= 1'b0; r_lm_d <= 1'b0;
      end else begin
         r_kl_s1 <= key_left;  r_kl_s2 <= r_kl_s1; r_kl_d <= r_kl_s2;
         r_kr_s1 <= key_right; r_kr_s2 <= r_kr_s1; r_kr_d <= r_kr_s2;
         r_lm_s1 <= lane_mode; r_lm_s2 <= r_lm_s1; r_lm_d <= r_lm_s2;
      end
   end

   assign w_kl_rise = r_kl_s2 & ~r_kl_d;
   assign w_kr_rise = r_kr_s2 & ~r_kr_d;
   assign w_lm_rise = r_lm_s2 & ~r_lm_d;

   // Motion state register
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_tick_cnt <= '0;
         r_h_pos    <= H_W'(START_H);
         r_lane     <= LANE_W'(START_LANE);
         r_speed    <= SPD_W'(STEP_MIN);
         r_hold     <= '0;
         r_dir      <= DIR_NONE;
         r_moving   <= 1'b0;
      end else begin
         r_tick_cnt <= n_tick;
         r_h_pos    <= n_pos;
         r_lane     <= n_lane;
         r_speed    <= n_speed;
         r_hold     <= n_hold;
         r_dir      <= n_dir;
         r_moving   <= n_moving;
      end
   end

   // Next-state: tick divider, lane selection, glide and steering
   always_comb begin
      w_tick     = (r_tick_cnt == TICK_W'(TICK_DIV));
      w_pos_x    = HX'(r_h_pos);
      w_tgt      = '0;
      w_new_x    = w_pos_x;
      w_spd_eff  = r_speed;
      w_hold_eff = r_hold;
      w_dir_eff  = r_dir;
      w_cur_dir  = DIR_NONE;
      w_hold_inc = '0;

      n_tick   = w_tick ? '0 : r_tick_cnt + TICK_W'(1);
      n_pos    = r_h_pos;
      n_lane   = r_lane;
      n_speed  = r_speed;
      n_hold   = r_hold;
      n_dir    = r_dir;
      n_moving = r_moving;

      if (reset_game) begin
         n_tick   = '0;
         n_pos    = H_W'(START_H);
         n_lane   = LANE_W'(START_LANE);
         n_speed  = SPD_W'(STEP_MIN);
         n_hold   = '0;
         n_dir    = DIR_NONE;
         n_moving = 1'b0;
      end else if (r_lm_s2) begin
         // Mode entry wins over key edges; simultaneous key edges cancel
         if (w_lm_rise) begin
            n_lane = LANE_W'(START_LANE);
         end else if (w_kl_rise && !w_kr_rise) begin
            n_lane = (r_lane == '0) ? r_lane : r_lane - LANE_W'(1);
         end else if (w_kr_rise && !w_kl_rise) begin
            n_lane = (r_lane == LANE_W'(NUM_LANES - 1)) ? r_lane : r_lane + LANE_W'(1);
         end
         // Glide toward the (possibly just retargeted) lane
         if (w_tick) begin
            w_tgt = f_target(n_lane);
            if (w_pos_x > w_tgt) begin
               w_new_x = ((w_pos_x - w_tgt) <= HX'(STEP_MAX)) ? w_tgt : w_pos_x - HX'(STEP_MAX);
            end else if (w_pos_x < w_tgt) begin
               w_new_x = ((w_tgt - w_pos_x) <= HX'(STEP_MAX)) ? w_tgt : w_pos_x + HX'(STEP_MAX);
            end
         end
      end else begin
         // Leaving lane mode drops any accumulated acceleration
         if (r_lm_d) begin
            w_spd_eff  = SPD_W'(STEP_MIN);
            w_hold_eff = '0;
            w_dir_eff  = DIR_NONE;
         end
         n_speed = w_spd_eff;
         n_hold  = w_hold_eff;
         n_dir   = w_dir_eff;
         if (w_tick) begin
            if (r_kl_s2 && !r_kr_s2)      w_cur_dir = DIR_LEFT;
            else if (r_kr_s2 && !r_kl_s2) w_cur_dir = DIR_RIGHT;

            if (w_cur_dir == DIR_NONE) begin
               n_speed = SPD_W'(STEP_MIN);
               n_hold  = '0;
               n_dir   = DIR_NONE;
            end else begin
               // A reversal restarts the ramp from the minimum step
               if ((w_dir_eff != DIR_NONE) && (w_dir_eff != w_cur_dir)) begin
                  w_spd_eff  = SPD_W'(STEP_MIN);
                  w_hold_eff = '0;
               end
               if (w_cur_dir == DIR_LEFT) begin
                  w_new_x = (w_pos_x < HX'(TRACK_L) + HX'(w_spd_eff)) ?
                            HX'(TRACK_L) : w_pos_x - HX'(w_spd_eff);
               end else begin
                  w_new_x = ((w_pos_x + HX'(w_spd_eff)) > HX'(MAX_H)) ?
                            HX'(MAX_H) : w_pos_x + HX'(w_spd_eff);
               end
               w_hold_inc = w_hold_eff + HOLD_W'(1);
               if (w_hold_inc >= HOLD_W'(RAMP_TICKS)) begin
                  n_hold  = '0;
                  n_speed = (w_spd_eff >= SPD_W'(STEP_MAX)) ?
                            SPD_W'(STEP_MAX) : w_spd_eff + SPD_W'(1);
               end else begin
                  n_hold  = w_hold_inc;
                  n_speed = w_spd_eff;
               end
               n_dir = w_cur_dir;
            end
         end
      end

      if (!reset_game && w_tick) begin
         n_pos    = w_new_x[H_W-1:0];
         n_moving = (w_new_x != w_pos_x);
      end
   end

   assign car_h_pos = r_h_pos;
   assign car_v_pos = V_W'(START_V);
   assign lane_idx  = r_lane;
   assign moving    = r_moving;
   assign at_left   = (r_h_pos == H_W'(TRACK_L));
   assign at_right  = (r_h_pos == H_W'(MAX_H));

endmodule
